div_unit: RTL and testbench

Parametrised multi-cycle integer divider for the execute stage of the five-stage pipeline. It computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, using one restoring-division step per clock. It stalls the pipeline while busy and honours an annul request from flush logic. Results are packed {remainder, quotient} so they can be written directly into the HI/LO register pair.

---
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (signed/unsigned) for the execute stage.
// Produces {remainder, quotient} for the HI/LO pair; stalls via busy_o, aborts on annul_i.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 dz_o,
  output logic                 busy_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_FREE, S_BY_ZERO, S_ON, S_END} state_t;

  state_t             state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [WIDTH-1:0]   rem, rem_d;
  logic [WIDTH-1:0]   quo, quo_d;
  logic [WIDTH-1:0]   dvs, dvs_d;
  logic               neg_q, neg_q_d;
  logic               neg_r, neg_r_d;
  logic [2*WIDTH-1:0] result_d;
  logic               ready_d, dz_d, busy_d;

  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   q_fin, r_fin;
  logic               a_neg, b_neg;

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rem_d    = rem;
    quo_d    = quo;
    dvs_d    = dvs;
    neg_q_d  = neg_q;
    neg_r_d  = neg_r;
    result_d = result_o;
    ready_d  = ready_o;
    dz_d     = dz_o;

    a_neg   = signed_div_i & opdata1_i[WIDTH-1];
    b_neg   = signed_div_i & opdata2_i[WIDTH-1];
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    q_fin   = neg_q ? (~quo + WIDTH'(1)) : quo;
    r_fin   = neg_r ? (~rem + WIDTH'(1)) : rem;

    unique case (state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          quo_d   = a_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
          dvs_d   = b_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          cnt_d   = '0;
          rem_d   = '0;
          state_d = (opdata2_i == '0) ? S_BY_ZERO : S_ON;
        end
      end
      S_BY_ZERO: begin
        state_d = annul_i ? S_FREE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else if (cnt == CW'(WIDTH)) begin
          result_d = {r_fin, q_fin};
          ready_d  = 1'b1;
          dz_d     = 1'b0;
          state_d  = S_END;
        end else begin
          // A non-negative trial difference (no borrow) yields quotient bit 1
          rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_d = {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt_d = cnt + CW'(1);
        end
      end
      S_END: begin
        // Arriving from BY_ZERO with ready still low: deliver the zero-divide result first
        if (annul_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
          dz_d     = 1'b0;
        end else if (!ready_o) begin
          result_d = '0;
          ready_d  = 1'b1;
          dz_d     = 1'b1;
        end else if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
          dz_d     = 1'b0;
        end
      end
      default: state_d = S_FREE;
    endcase

    busy_d = (state_d == S_BY_ZERO) || (state_d == S_ON);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
      dz_o     <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rem      <= rem_d;
      quo      <= quo_d;
      dvs      <= dvs_d;
      neg_q    <= neg_q_d;
      neg_r    <= neg_r_d;
      result_o <= result_d;
      ready_o  <= ready_d;
      dz_o     <= dz_d;
      busy_o   <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32 plus a WIDTH=8 instance).
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sd, annul;
  logic [31:0] a, b;
  logic [63:0] res;
  logic        ready, dz, busy;

  logic        start8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        ready8, dz8, busy8;
  logic        sd8 = 1'b0;
  logic        annul8 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .signed_div_i(sd),
    .opdata1_i(a), .opdata2_i(b), .annul_i(annul),
    .result_o(res), .ready_o(ready), .dz_o(dz), .busy_o(busy)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .signed_div_i(sd8),
    .opdata1_i(a8), .opdata2_i(b8), .annul_i(annul8),
    .result_o(res8), .ready_o(ready8), .dz_o(dz8), .busy_o(busy8)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // First tick is the start edge; lat counts edges after it until ready_o
  task automatic wait_done(input int limit, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    tick();
    if (busy) bcnt++;
    while (!ready && lat < limit) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp_res,
                        input logic exp_dz, input int exp_lat, input int exp_busy);
    int lat, bc;
    sd = s; a = x; b = y; start = 1'b1;
    wait_done(60, lat, bc);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(bc), 64'(exp_busy));
    check({tag, "_res"}, res, exp_res);
    check({tag, "_dz"}, 64'(dz), 64'(exp_dz));
    a = '1; b = '1; sd = ~s;
    tick();
    check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
    check({tag, "_hold_res"}, res, exp_res);
    start = 1'b0;
    tick();
    check({tag, "_exit_rdy"}, 64'(ready), 64'd0);
    check({tag, "_exit_res"}, res, 64'd0);
    check({tag, "_exit_dz"}, 64'(dz), 64'd0);
  endtask

  initial begin
    int lat, bc;
    bit seen;
    rst = 1'b0; start = 1'b0; sd = 1'b0; annul = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick();
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    check("rst_res", res, 64'd0);
    rst = 1'b1;
    tick();

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33, 33);
    run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33, 33);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 33, 33);
    run_op("u_f9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 1'b0, 33, 33);
    run_op("dz5", 1'b0, 32'd5, 32'd0, 64'd0, 1'b1, 2, 1);
    run_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33, 33);
    run_op("u_8k_ff", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 1'b0, 33, 33);
    run_op("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0, 33, 33);

    // Annul at iteration 10
    sd = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    seen = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready) seen = 1'b1;
    end
    annul = 1'b1;
    tick();
    if (ready) seen = 1'b1;
    check("annul_noready", 64'(seen), 64'd0);
    check("annul_busy", 64'(busy), 64'd0);
    check("annul_res", res, 64'd0);
    annul = 1'b0; start = 1'b0;
    tick();
    run_op("post_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33, 33);

    // Annul in FREE blocks start
    annul = 1'b1; start = 1'b1; a = 32'd9; b = 32'd3;
    tick(); tick();
    check("free_annul_busy", 64'(busy), 64'd0);
    check("free_annul_rdy", 64'(ready), 64'd0);
    annul = 1'b0; start = 1'b0;
    tick();

    // Reset at iteration 5, start held throughout
    sd = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    tick();
    check("mrst_ready", 64'(ready), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_res", res, 64'd0);
    check("mrst_dz", 64'(dz), 64'd0);
    tick();
    check("mrst_hold_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    wait_done(60, lat, bc);
    check("mrst_restart_lat", 64'(lat), 64'd33);
    check("mrst_restart_res", res, 64'h00000002_0000000E);
    start = 1'b0;
    tick();

    // WIDTH=8: 13 / 3
    a8 = 8'd13; b8 = 8'd3; start8 = 1'b1;
    tick();
    lat = 0;
    while (!ready8 && lat < 30) begin
      tick();
      lat++;
    end
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_res", 64'(res8), 64'h0104);
    check("w8_dz", 64'(dz8), 64'd0);
    start8 = 1'b0;
    tick();
    check("w8_exit_rdy", 64'(ready8), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
